// File: rtl/lfsr_drop_mask_gen.sv
// Drives the 12-bit LFSR (reseed/step) and packs threshold comparisons
// of its output into MASK_W-bit keep/drop words on a valid/ready stream.
module lfsr_drop_mask_gen #(
    parameter int MASK_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [11:0]       threshold,
    input  logic [11:0]       rand_num,
    output logic              load_data,
    output logic              gen_random,
    output logic [MASK_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W+5:0]  keep_cnt
);

    localparam int BW = (MASK_W > 1) ? $clog2(MASK_W) : 1;
    localparam int KW = CNT_W + 6;

    typedef enum logic [2:0] {IDLE, SEED, GEN, OUT, FIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  nw_q, nw_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [11:0]       thr_q, thr_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [MASK_W-1:0] sr_q, sr_d;
    logic [MASK_W-1:0] data_q, data_d;
    logic [KW-1:0]     keep_q, keep_d;

    logic smp;
    logic word_end;
    logic is_last;

    assign smp      = (rand_num >= thr_q);
    assign word_end = (bit_idx_q == BW'(MASK_W - 1));
    assign is_last  = (word_idx_q == nw_q - CNT_W'(1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (num_words != '0) ? SEED : FIN;
            SEED: state_d = GEN;
            GEN:  if (word_end) state_d = OUT;
            OUT:  if (m_ready) state_d = is_last ? FIN : GEN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_data  = 1'b0;
        gen_random = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            IDLE: busy = 1'b0;
            SEED: load_data = 1'b1;
            GEN:  gen_random = 1'b1;
            OUT: begin
                m_valid = 1'b1;
                m_last  = is_last;
            end
            FIN:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign m_data   = data_q;
    assign keep_cnt = keep_q;

    always_comb begin
        nw_d       = nw_q;
        thr_d      = thr_q;
        word_idx_d = word_idx_q;
        bit_idx_d  = bit_idx_q;
        sr_d       = sr_q;
        data_d     = data_q;
        keep_d     = keep_q;
        unique case (state_q)
            IDLE: if (start) begin
                nw_d       = num_words;
                thr_d      = threshold;
                keep_d     = '0;
                word_idx_d = '0;
                bit_idx_d  = '0;
            end
            GEN: begin
                sr_d[bit_idx_q] = smp;
                if (smp && keep_q != '1) keep_d = keep_q + KW'(1);
                if (word_end) begin
                    bit_idx_d = '0;
                    data_d    = sr_d;
                end else begin
                    bit_idx_d = bit_idx_q + BW'(1);
                end
            end
            OUT: if (m_ready && !is_last) word_idx_d = word_idx_q + CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            nw_q       <= '0;
            thr_q      <= '0;
            word_idx_q <= '0;
            bit_idx_q  <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            keep_q     <= '0;
        end else begin
            nw_q       <= nw_d;
            thr_q      <= thr_d;
            word_idx_q <= word_idx_d;
            bit_idx_q  <= bit_idx_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
        end
    end

endmodule

// File: tb/tb_lfsr_drop_mask_gen.sv
// Directed bench for lfsr_drop_mask_gen with a behavioural 12-bit LFSR
// (seed 0xAA7, next value 0xFD9) feeding rand_num.
module tb_lfsr_drop_mask_gen;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = '0;
    logic [11:0] threshold = '0;
    logic [11:0] rand_num;
    logic        load_data, gen_random;
    logic [15:0] m_data;
    logic        m_valid, m_last, busy, done;
    logic        m_ready = 1'b0;
    logic [21:0] keep_cnt;
    logic [11:0] lfsr = '0;

    int errors = 0;
    int checks = 0;

    lfsr_drop_mask_gen #(.MASK_W(16), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .num_words(num_words),
        .threshold(threshold), .rand_num(rand_num),
        .load_data(load_data), .gen_random(gen_random),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done), .keep_cnt(keep_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] nxt(input logic [11:0] v);
        return {v[10:0], 1'b0} ^ (v[11] ? 12'hA97 : 12'h000);
    endfunction

    always @(posedge CLK) begin
        if (load_data) lfsr <= 12'hAA7;
        else if (gen_random) lfsr <= nxt(lfsr);
    end
    assign rand_num = lfsr;

    function automatic logic [15:0] exp_word(input int w, input logic [11:0] thr);
        logic [11:0] v;
        logic [15:0] r;
        v = 12'hAA7;
        r = '0;
        for (int i = 0; i < w * 16; i++) v = nxt(v);
        for (int b = 0; b < 16; b++) begin
            r[b] = (v >= thr);
            v = nxt(v);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge CLK);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 100) begin
            cyc;
            n++;
        end
        chk(tag, 64'(m_valid), 64'd1);
    endtask

    task automatic kick(input logic [15:0] nw, input logic [11:0] thr);
        start = 1'b1;
        num_words = nw;
        threshold = thr;
        cyc;
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] w0, exp0;
        int genc, words, lastpos, bad, donec, donefirst, act;

        // reset state
        cyc;
        #1;
        chk("rst_outs", 64'({load_data, gen_random, m_valid, m_last, busy, done}), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_keep", 64'(keep_cnt), 64'd0);
        cyc;
        RST_N = 1'b1;
        cyc;

        // single word, threshold 3000
        kick(16'd1, 12'd3000);
        chk("t1_load", 64'({load_data, gen_random, busy}), 64'b101);
        genc = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            cyc;
            if (gen_random) genc++;
            if (load_data || m_valid) bad++;
        end
        chk("t1_gen_cnt", 64'(genc), 64'd16);
        chk("t1_no_overlap", 64'(bad), 64'd0);
        cyc;
        exp0 = exp_word(0, 12'd3000);
        chk("t1_valid_last", 64'({m_valid, m_last, gen_random}), 64'b110);
        chk("t1_data", 64'(m_data), 64'(exp0));
        w0 = m_data;
        chk("t1_bit0_bit1", 64'(w0[1:0]), 64'b10);
        m_ready = 1'b1;
        cyc;
        m_ready = 1'b0;
        chk("t1_done", 64'({done, m_valid}), 64'b10);
        chk("t1_keep", 64'(keep_cnt), 64'($countones(exp0)));
        cyc;
        chk("t1_idle", 64'({done, busy}), 64'b00);

        // threshold 0, three words, consumer always ready
        m_ready = 1'b1;
        kick(16'd3, 12'd0);
        words = 0;
        lastpos = -1;
        bad = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (m_valid) begin
                if (m_data !== 16'hFFFF) bad++;
                if (m_last) lastpos = words;
                words++;
            end
            cyc;
        end
        m_ready = 1'b0;
        chk("t2_words", 64'(words), 64'd3);
        chk("t2_lastpos", 64'(lastpos), 64'd2);
        chk("t2_data", 64'(bad), 64'd0);
        chk("t2_keep", 64'(keep_cnt), 64'd48);
        cyc;

        // backpressure on word 0, plus a start while busy
        kick(16'd2, 12'd3000);
        wait_valid("t3_v0");
        w0 = m_data;
        chk("t3_w0", 64'(w0), 64'(exp_word(0, 12'd3000)));
        chk("t3_w0_last", 64'(m_last), 64'd0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                start = 1'b1;
                num_words = 16'd5;
                threshold = 12'd0;
            end
            cyc;
            start = 1'b0;
            chk("t3_hold", 64'({m_valid, gen_random, m_data == w0}), 64'b101);
        end
        m_ready = 1'b1;
        cyc;
        m_ready = 1'b0;
        chk("t3_drop", 64'(m_valid), 64'd0);
        wait_valid("t3_v1");
        chk("t3_w1", 64'(m_data), 64'(exp_word(1, 12'd3000)));
        chk("t3_w1_last", 64'(m_last), 64'd1);
        m_ready = 1'b1;
        cyc;
        m_ready = 1'b0;
        chk("t3_done", 64'(done), 64'd1);
        cyc;
        chk("t3_idle", 64'(busy), 64'd0);

        // empty burst
        kick(16'd0, 12'd100);
        donec = 0;
        donefirst = 0;
        act = 0;
        for (int t = 1; t <= 4; t++) begin
            if (done) begin
                donec++;
                if (donefirst == 0) donefirst = t;
            end
            if (load_data || gen_random || m_valid) act++;
            cyc;
        end
        chk("t4_activity", 64'(act), 64'd0);
        chk("t4_done_cnt", 64'(donec), 64'd1);
        chk("t4_done_when", 64'(donefirst >= 1 && donefirst <= 2), 64'd1);

        // asynchronous reset in the middle of word 1
        m_ready = 1'b1;
        kick(16'd2, 12'd0);
        wait_valid("t5_v0");
        cyc;
        m_ready = 1'b0;
        cyc;
        cyc;
        chk("t5_in_gen", 64'(gen_random), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("t5_rst_outs", 64'({load_data, gen_random, m_valid, m_last, busy, done}), 64'd0);
        chk("t5_rst_data", 64'({m_data, keep_cnt}), 64'd0);
        cyc;
        RST_N = 1'b1;
        cyc;
        kick(16'd1, 12'hAA7);
        wait_valid("t5_v");
        w0 = m_data;
        chk("t5_reseed", 64'(w0), 64'(exp_word(0, 12'hAA7)));
        chk("t5_bit0", 64'(w0[0]), 64'd1);
        m_ready = 1'b1;
        cyc;
        m_ready = 1'b0;
        chk("t5_done", 64'(done), 64'd1);
        cyc;

        // threshold at maximum
        kick(16'd1, 12'hFFF);
        wait_valid("t6_v");
        exp0 = exp_word(0, 12'hFFF);
        chk("t6_data", 64'(m_data), 64'(exp0));
        chk("t6_keep", 64'(keep_cnt), 64'($countones(exp0)));
        m_ready = 1'b1;
        cyc;
        m_ready = 1'b0;
        cyc;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
